// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
//
// Shared definitions for the MIPS core execute stage:
//   - ALU operation encodings driven on the shared ALU's alu_op input
//   - multiply/divide unit operation select values
//   - state encoding of the multiply/divide sequencer FSM
// ---------------------------------------------------------------------------
package mips_pkg;

    // Shared ALU operation codes
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Multiply/divide unit operation select
    localparam logic MDU_MULTU = 1'b0;
    localparam logic MDU_DIVU  = 1'b1;

    // Multiply/divide sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/mips_alu.sv
// ---------------------------------------------------------------------------
// mips_alu
//
// The 32-bit ALU of the execute stage. The multiply/divide sequencer borrows
// it while iterating, so ADD and SUB expose the carry out of bit 31.
//
// Ports:
//   alu_op     in   3   operation select (mips_pkg ALU_* codes)
//   a          in   32  operand A
//   b          in   32  operand B
//   alu_out    out  32  result
//   carry_out  out  1   carry of bit 31 for ADD / SUB (SUB: 1 = no borrow)
//   zero_flag  out  1   alu_out == 0
// ---------------------------------------------------------------------------
module mips_alu
    import mips_pkg::*;
(
    input  logic [2:0]  alu_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] alu_out,
    output logic        carry_out,
    output logic        zero_flag
);

    logic [32:0] sum33;

    // SUB is computed as A + ~B + 1 so that carry_out = 1 means no borrow.
    // SLT reuses the subtraction and corrects the sign for overflow by
    // looking at the operand signs directly when they differ.
    always_comb begin
        sum33     = '0;
        alu_out   = '0;
        carry_out = 1'b0;
        case (alu_op)
            ALU_AND: alu_out = a & b;
            ALU_OR:  alu_out = a | b;
            ALU_ADD: begin
                sum33     = {1'b0, a} + {1'b0, b};
                alu_out   = sum33[31:0];
                carry_out = sum33[32];
            end
            ALU_SUB: begin
                sum33     = {1'b0, a} + {1'b0, ~b} + 33'd1;
                alu_out   = sum33[31:0];
                carry_out = sum33[32];
            end
            ALU_SLT: begin
                sum33   = {1'b0, a} + {1'b0, ~b} + 33'd1;
                alu_out = {31'b0, (a[31] ^ b[31]) ? a[31] : sum33[31]};
            end
            default: alu_out = '0;
        endcase
    end

    assign zero_flag = (alu_out == '0);

endmodule

// File: rtl/mdu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mdu_seq_ctrl
//
// Multi-cycle MULTU / DIVU sequencer. Owns the HI/LO registers and performs
// one shift-add (multiply) or restoring-divide step per cycle using the
// shared ALU instead of a private adder. A start is accepted from IDLE or
// DONE; the pipeline stalls on busy until done pulses.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   start      in   1   operation request, ignored while busy
//   op         in   1   0 = MULTU, 1 = DIVU
//   src_a      in   32  multiplicand / dividend
//   src_b      in   32  multiplier / divisor
//   busy       out  1   high while iterating
//   done       out  1   one-cycle pulse when hi/lo are valid
//   div_zero   out  1   DIVU with divisor 0, held until next start
//   hi         out  32  product[63:32] / remainder
//   lo         out  32  product[31:0]  / quotient
//   alu_op     out  3   to ALU op select
//   alu_a      out  32  to ALU A
//   alu_b      out  32  to ALU B
//   alu_out    in   32  from ALU result
//   alu_carry  in   1   from ALU carry_out
// ---------------------------------------------------------------------------
module mdu_seq_ctrl
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mdu_state_e       state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_q, op_d;
    logic             div_zero_q, div_zero_d;

    logic [WIDTH-1:0] div_shift;
    logic             div_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hi_q       <= '0;
            lo_q       <= '0;
            opnd_q     <= '0;
            cnt_q      <= '0;
            op_q       <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            opnd_q     <= opnd_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            div_zero_q <= div_zero_d;
        end
    end

    // Next-state, iteration datapath and ALU drive
    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        opnd_d     = opnd_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        div_zero_d = div_zero_q;
        busy       = 1'b0;
        done       = 1'b0;
        alu_op     = ALU_AND;
        alu_a      = '0;
        alu_b      = '0;

        // Partial remainder shifted left by one, pulling in the next
        // dividend bit. If its top bit was already set before the shift the
        // value exceeds WIDTH bits, so the subtraction must always be taken
        // even though the ALU reports a borrow.
        div_shift = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        div_q     = hi_q[WIDTH-1] | alu_carry;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end

            RUN: begin
                busy  = 1'b1;
                alu_b = opnd_q;
                if (op_q == MDU_MULTU) begin
                    alu_op = ALU_ADD;
                    alu_a  = hi_q;
                    // The ALU carry becomes the new top bit of HI so the
                    // 33-bit partial sum is kept across the shift.
                    if (lo_q[0]) begin
                        {hi_d, lo_d} = {alu_carry, alu_out, lo_q[WIDTH-1:1]};
                    end else begin
                        {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
                    end
                end else begin
                    alu_op = ALU_SUB;
                    alu_a  = div_shift;
                    hi_d   = div_q ? alu_out : div_shift;
                    lo_d   = {lo_q[WIDTH-2:0], div_q};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                done    = 1'b1;
                state_d = start ? RUN : IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Operand capture on an accepted start. Divide keeps the divisor in
        // opnd and shifts the dividend out of LO; multiply keeps the
        // multiplicand in opnd and shifts the multiplier out of LO.
        if (start && (state_q != RUN)) begin
            op_d       = op;
            opnd_d     = (op == MDU_DIVU) ? src_b : src_a;
            lo_d       = (op == MDU_DIVU) ? src_a : src_b;
            hi_d       = '0;
            cnt_d      = '0;
            div_zero_d = (op == MDU_DIVU) && (src_b == '0);
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mdu_seq_ctrl
//
// Scoreboard bench for mdu_seq_ctrl wired to the real mips_alu. Directed
// operations push their hand-computed results into a queue; a monitor pops
// and compares whenever done is seen.
// ---------------------------------------------------------------------------
module tb_mdu_seq_ctrl;
    import mips_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [2:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_out;
    logic        alu_carry;
    logic        alu_zero;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc;
    int   busyCnt;

    mdu_seq_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .hi        (hi),
        .lo        (lo),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_out   (alu_out),
        .alu_carry (alu_carry)
    );

    mips_alu alu (
        .alu_op    (alu_op),
        .a         (alu_a),
        .b         (alu_b),
        .alu_out   (alu_out),
        .carry_out (alu_carry),
        .zero_flag (alu_zero)
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison: counts it, reports a FAIL line on mismatch
    task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    // Issue one start pulse (called just after a falling edge) and record
    // the expected result. Returns just after the next falling edge, i.e.
    // in the first RUN cycle.
    task automatic applyStimulus(input logic o, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] eh, input logic [31:0] el,
                                 input logic ez, input string nm);
        exp_t e;
        e.hi = eh;
        e.lo = el;
        e.dz = ez;
        e.name = nm;
        expQ.push_back(e);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Step falling edges until done, bounded; reports cycles waited and
    // how many of those cycles had busy high
    task automatic waitDone(input string nm, output int cycles, output int busyCycles);
        cycles     = 0;
        busyCycles = 0;
        while (!done && cycles < 50) begin
            if (busy) busyCycles++;
            @(negedge clk);
            cycles++;
        end
        checkOutput({nm, "_done_seen"}, {63'b0, done}, 64'd1);
    endtask

    // Monitor: every done pulse is matched against the scoreboard head
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done actual=1 expected=0");
            end else begin
                e = expQ.pop_front();
                checkOutput({e.name, "_hi"}, {32'b0, hi}, {32'b0, e.hi});
                checkOutput({e.name, "_lo"}, {32'b0, lo}, {32'b0, e.lo});
                checkOutput({e.name, "_div_zero"}, {63'b0, div_zero}, {63'b0, e.dz});
            end
        end
    end

    // Hard time limit so the run can never hang
    initial begin
        #100000;
        $display("[TB] FAIL global_timeout actual=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    // Directed sequence
    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        src_a = '0;
        src_b = '0;
        #2;
        checkOutput("reset_busy", {63'b0, busy}, 64'd0);
        checkOutput("reset_done", {63'b0, done}, 64'd0);
        checkOutput("reset_div_zero", {63'b0, div_zero}, 64'd0);
        checkOutput("reset_hi", {32'b0, hi}, 64'd0);
        checkOutput("reset_lo", {32'b0, lo}, 64'd0);
        checkOutput("reset_alu_op", {61'b0, alu_op}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: MULTU 7 x 6 with latency and pulse-width checks
        applyStimulus(MDU_MULTU, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, "mul_7x6");
        waitDone("mul_7x6", cyc, busyCnt);
        checkOutput("mul_7x6_latency", 64'(cyc + 1), 64'd33);
        checkOutput("mul_7x6_busy_cycles", 64'(busyCnt), 64'd32);
        @(negedge clk);
        checkOutput("mul_7x6_done_pulse", {63'b0, done}, 64'd0);
        checkOutput("mul_7x6_idle_busy", {63'b0, busy}, 64'd0);
        repeat (3) @(negedge clk);
        checkOutput("mul_7x6_lo_hold", {32'b0, lo}, 64'd42);

        // 2: MULTU all ones, carry into HI
        applyStimulus(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, "mul_max");
        waitDone("mul_max", cyc, busyCnt);
        @(negedge clk);

        // 3: DIVU 100 / 7
        applyStimulus(MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "div_100_7");
        waitDone("div_100_7", cyc, busyCnt);
        @(negedge clk);

        // 4: DIVU with shifted remainder overflowing 32 bits
        applyStimulus(MDU_DIVU, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 32'd1, 1'b0, "div_ovf");
        waitDone("div_ovf", cyc, busyCnt);
        @(negedge clk);

        // 5: DIVU by zero, then MULTU started in the DONE cycle
        applyStimulus(MDU_DIVU, 32'h3039, 32'd0, 32'h3039, 32'hFFFFFFFF, 1'b1, "div_zero");
        waitDone("div_zero", cyc, busyCnt);
        applyStimulus(MDU_MULTU, 32'd3, 32'd3, 32'd0, 32'd9, 1'b0, "mul_b2b");
        checkOutput("mul_b2b_busy", {63'b0, busy}, 64'd1);
        waitDone("mul_b2b", cyc, busyCnt);
        checkOutput("mul_b2b_latency", 64'(cyc + 1), 64'd33);
        @(negedge clk);

        // 6a: start pulsed during RUN is ignored
        applyStimulus(MDU_MULTU, 32'd5, 32'd5, 32'd0, 32'd25, 1'b0, "mul_ign");
        repeat (9) @(negedge clk);
        start = 1'b1;
        op    = MDU_DIVU;
        src_a = 32'd100;
        src_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        waitDone("mul_ign", cyc, busyCnt);
        @(negedge clk);
        checkOutput("mul_ign_no_restart", {63'b0, busy}, 64'd0);

        // 6b: asynchronous reset in RUN cycle 20
        applyStimulus(MDU_MULTU, 32'd5, 32'd5, 32'd0, 32'd25, 1'b0, "mul_abort");
        repeat (19) @(negedge clk);
        checkOutput("abort_busy_before", {63'b0, busy}, 64'd1);
        rst_n = 1'b0;
        void'(expQ.pop_back());
        #1;
        checkOutput("abort_busy", {63'b0, busy}, 64'd0);
        checkOutput("abort_done", {63'b0, done}, 64'd0);
        checkOutput("abort_hi", {32'b0, hi}, 64'd0);
        checkOutput("abort_lo", {32'b0, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abort_stays_idle", {63'b0, busy}, 64'd0);

        // 6c: DIVU 9 / 2 after reset
        applyStimulus(MDU_DIVU, 32'd9, 32'd2, 32'd1, 32'd4, 1'b0, "div_9_2");
        waitDone("div_9_2", cyc, busyCnt);
        repeat (3) @(negedge clk);

        checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
